mem_port: RTL

- Bus responder on the far side of the control sequencer's memory-phase strobes.
- Accepts one request per instruction phase (instruction fetch, data load, data store) and runs the access against the synchronous RAM or the I/O port space, with configurable wait states.
- Returns read data, a one-cycle completion strobe, and a busy flag that the sequencer uses to hold its current state.
- Sits between the control/datapath and the memory and I/O buses.

---
 rtl/mem_port_pkg.sv | 33 +++
 rtl/mem_port_if.sv | 45 ++++
 rtl/mem_port_wait_counter.sv | 29 ++
 rtl/mem_port.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory/I-O bus responder: word width, wait
// counter width, state codes and request-kind codes.
package mem_port_pkg;

    localparam int WORD_SIZE = 16;
    localparam int WAIT_W    = 4;

    typedef enum logic [1:0] {
        MP_IDLE   = 2'd0,
        MP_ACCESS = 2'd1,
        MP_DONE   = 2'd2
    } mp_state_t;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } req_kind_t;

    // Resolves simultaneous requests: fetch beats load beats store.
    function automatic req_kind_t pick_kind(input logic fetch, input logic load);
        req_kind_t kind;
        if (fetch) begin
            kind = KIND_FETCH;
        end else if (load) begin
            kind = KIND_LOAD;
        end else begin
            kind = KIND_STORE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/mem_port_if.sv
// Bundle of every bus signal around mem_port. The slave side is the
// responder itself; the master side is the rest of the system (sequencer,
// RAM and I/O devices) that drives requests and returns read data.
interface mem_port_if #(
    parameter int WORD_SIZE = mem_port_pkg::WORD_SIZE
);

    logic                 req_fetch;
    logic                 req_load;
    logic                 req_store;
    logic                 req_io;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] rdata;
    logic                 done;
    logic                 busy;
    logic                 err;
    logic                 mem_en;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 io_re;
    logic                 io_we;
    logic [WORD_SIZE-1:0] io_addr;
    logic [WORD_SIZE-1:0] io_wdata;
    logic [WORD_SIZE-1:0] io_rdata;

    modport master (
        output req_fetch, req_load, req_store, req_io, addr, wdata,
        output mem_rdata, io_rdata,
        input  rdata, done, busy, err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  io_re, io_we, io_addr, io_wdata
    );

    modport slave (
        input  req_fetch, req_load, req_store, req_io, addr, wdata,
        input  mem_rdata, io_rdata,
        output rdata, done, busy, err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output io_re, io_we, io_addr, io_wdata
    );

endinterface

// File: rtl/mem_port_wait_counter.sv
// Four-bit wait-state down-counter: loaded when a request is accepted,
// decremented once per access cycle, and reporting when it reaches zero.
module wait_counter
    import mem_port_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    // Load takes precedence over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port.sv
// Memory-phase bus responder. Accepts one fetch/load/store per instruction
// phase, drives the RAM or I/O strobes for 1+wait cycles, captures read
// data on the last access cycle and pulses done for one cycle afterwards.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int WORD_SIZE = mem_port_pkg::WORD_SIZE,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    mem_port_if.slave  bus
);

    localparam logic [WAIT_W-1:0] MEM_WAIT_V = WAIT_W'(MEM_WAIT);
    localparam logic [WAIT_W-1:0] IO_WAIT_V  = WAIT_W'(IO_WAIT);

    mp_state_t            state;
    mp_state_t            state_next;
    req_kind_t            kind_q;
    logic                 io_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;

    logic                 any_req;
    logic                 multi_req;
    logic                 accept;
    logic                 req_is_io;
    logic [WAIT_W-1:0]    wait_value;
    logic                 wait_dec;
    logic                 wait_zero;

    assign any_req   = bus.req_fetch | bus.req_load | bus.req_store;
    assign multi_req = (bus.req_fetch & bus.req_load) |
                       (bus.req_fetch & bus.req_store) |
                       (bus.req_load  & bus.req_store);
    assign accept    = (state == MP_IDLE) && any_req;
    // Fetches always go to RAM, so the io qualifier only matters for load/store.
    assign req_is_io = bus.req_io & ~bus.req_fetch;
    assign wait_value = req_is_io ? IO_WAIT_V : MEM_WAIT_V;
    assign wait_dec  = (state == MP_ACCESS) && !wait_zero;

    wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (wait_value),
        .dec        (wait_dec),
        .zero       (wait_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one access per request, then a single DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            MP_IDLE:   if (any_req)   state_next = MP_ACCESS;
            MP_ACCESS: if (wait_zero) state_next = MP_DONE;
            MP_DONE:                  state_next = MP_IDLE;
            default:                  state_next = MP_IDLE;
        endcase
    end

    // Request latch: captured only on acceptance, so later requests cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q  <= KIND_FETCH;
            io_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            kind_q  <= pick_kind(bus.req_fetch, bus.req_load);
            io_q    <= req_is_io;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Read-data register: updated on the final access cycle of a fetch or load only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if ((state == MP_ACCESS) && wait_zero && (kind_q != KIND_STORE)) begin
            rdata_q <= io_q ? bus.io_rdata : bus.mem_rdata;
        end
    end

    // Bus outputs: strobes and latched address/data only in ACCESS, everything forced low under reset.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.io_re     = 1'b0;
        bus.io_we     = 1'b0;
        bus.io_addr   = '0;
        bus.io_wdata  = '0;
        if (!reset && (state == MP_ACCESS)) begin
            if (io_q) begin
                bus.io_re    = (kind_q == KIND_LOAD);
                bus.io_we    = (kind_q == KIND_STORE);
                bus.io_addr  = addr_q;
                bus.io_wdata = wdata_q;
            end else begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = (kind_q == KIND_STORE);
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
        end
    end

    // Handshake outputs: busy holds the sequencer, err flags overlapping or out-of-turn requests.
    always_comb begin
        bus.done  = 1'b0;
        bus.busy  = 1'b0;
        bus.err   = 1'b0;
        bus.rdata = '0;
        if (!reset) begin
            bus.done  = (state == MP_DONE);
            bus.busy  = accept || (state == MP_ACCESS);
            bus.err   = (state == MP_IDLE) ? multi_req : any_req;
            bus.rdata = rdata_q;
        end
    end

endmodule
